lifo_param: RTL
===============

Name: lifo_param

Overview:
- Parametrised successor to the fixed 8-entry, 8-bit stack.
- Configurable data width and depth, with the top two entries held in registers (o_s0, o_s1) for zero-latency operand access.
- Adds an occupancy count, full/empty flags, sticky overflow/underflow error flags, and a replace-top mode (push and pop in the same cycle).
- Serves as the operand/return stack primitive for the uFork core and the FPGA test fixtures.

Parameters:
WIDTH, 8, bit width of each stack entry
DEPTH, 16, total entry capacity including s0/s1 (legal range 2..256)

Ports:
i_clk  in  1  system clock, all state changes on rising edge
i_rst  in  1  synchronous reset, active-high
i_data  in  WIDTH  value to push or to replace top
i_push  in  1  push request, sampled each clock
i_pop  in  1  pop request, sampled each clock
o_s0  out  WIDTH  top of stack (0 when empty)
o_s1  out  WIDTH  next-on-stack (0 when count < 2)
o_cnt  out  clog2(DEPTH+1)  number of valid entries, 0..DEPTH
o_empty  out  1  o_cnt == 0 (combinational from o_cnt)
o_full  out  1  o_cnt == DEPTH (combinational from o_cnt)
o_overflow  out  1  sticky: a push was refused because the stack was full
o_underflow  out  1  sticky: a pop or replace was refused because the stack was empty

Behaviour:
- Reset (i_rst=1 at the clock edge; overrides push/pop in the same cycle):
  - o_cnt=0, o_s0=0, o_s1=0, o_overflow=0, o_underflow=0.
  - Spill-array contents are not cleared and never become observable after reset.
- Storage:
  - s0 and s1 are registers.
  - Entries 3..DEPTH live in a spill array of DEPTH-2 words, indexed 0 at the bottom.
  - Spill read is asynchronous (LUT RAM or registers).
  - With DEPTH=2 the spill array is absent.
- Latency: every operation takes effect at the clock edge; o_s0, o_s1, o_cnt, flags and error bits are valid the next cycle. No stall or handshake; a request is accepted or refused in a single cycle.
- Operation select on {i_push, i_pop} when not in reset:
  - 00 idle: no state change.
  - 10 push:
    - If full: set o_overflow; s0, s1, cnt unchanged.
    - Else: s0<=i_data; s1<=old s0; cnt<=cnt+1.
    - If cnt>=2 before the push: spill[cnt-2]<=old s1.
  - 01 pop:
    - If empty: set o_underflow; no other change.
    - Else: s0<=old s1; cnt<=cnt-1.
    - s1<=spill[cnt-3] if cnt>=3, else s1<=0.
  - 11 replace top:
    - If empty: set o_underflow; no other change.
    - Else: s0<=i_data; s1, spill, cnt unchanged.
    - Legal when full; does not set o_overflow.
- Invariants:
  - Registers for entries beyond cnt hold 0: s0=0 when cnt=0, s1=0 when cnt<2.
  - A pop that leaves cnt=1 clears s1; a pop to cnt=0 clears s0.
  - o_cnt never wraps: push at DEPTH and pop at 0 are refused, not wrapped.
- Error flags:
  - Set on the refusing edge and remain 1 until i_rst.
  - Both may be 1 simultaneously.
  - A refused request does not disturb stack contents.
- Width rules:
  - Count width is clog2(DEPTH+1); DEPTH=256 gives 9 bits.
  - Spill index arithmetic uses count width and is evaluated only under the guards above, so no negative indices arise.

Test Plan (WIDTH=8, DEPTH=4 unless noted):
- Reset, then idle 2 cycles -> o_cnt=0, o_s0=00, o_s1=00, o_empty=1, o_full=0, both error flags 0.
- Push D5, push 7A, pop -> after pushes s0=7A, s1=D5, cnt=2; after pop s0=D5, s1=00, cnt=1 (matches original single push/pop script, extended).
- Push 11,22,33,44 -> s0=44, s1=33, cnt=4, o_full=1. Push 55 -> overflow=1, s0=44, cnt=4. Four pops -> s0 sequence 33,22,11,00 and s1 sequence 22,11,00,00, then o_empty=1.
- From empty: pop -> underflow=1, cnt=0. Push+pop with data 99 -> underflow stays 1, cnt=0, s0=00.
- Push 01, push 02; push+pop with data EE -> s0=EE, s1=01, cnt=2. Pop -> s0=01, cnt=1.
- Push 3 values, assert i_rst together with i_push for one cycle -> cnt=0, s0=00, flags cleared. Push A0 -> s0=A0, s1=00 (no stale spill data). Repeat fill/drain with DEPTH=2 and DEPTH=256 for boundary sizes.

Source files
------------

// File: rtl/lifo_param.sv
// lifo_param: parametrised LIFO stack with registered top two entries, spill array, occupancy and sticky error flags
module lifo_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_push,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_s0,
   output logic [WIDTH-1:0]           o_s1,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_overflow,
   output logic                       o_underflow
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int SD = (DEPTH > 2) ? DEPTH - 2 : 1;
   localparam int AW = (SD > 1) ? $clog2(SD) : 1;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, spill_rd;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             do_push, do_pop, do_rep;
   assign o_empty  = cnt_q == '0;
   assign o_full   = cnt_q == CW'(DEPTH);
   assign do_push  = i_push & ~i_pop & ~o_full;
   assign do_pop   = i_pop & ~i_push & ~o_empty;
   assign do_rep   = i_push & i_pop & ~o_empty;
   generate
      if (DEPTH > 2) begin : g_spill
         logic [WIDTH-1:0] spill_q [SD];
         logic [AW-1:0]    wr_idx, rd_idx;
         assign wr_idx   = AW'(cnt_q - CW'(2));
         assign rd_idx   = AW'(cnt_q - CW'(3));
         assign spill_rd = spill_q[rd_idx];
         // Spill contents are deliberately left out of reset; cnt gates their visibility.
         always_ff @(posedge i_clk)
            if (!i_rst && do_push && cnt_q >= CW'(2)) spill_q[wr_idx] <= s1_q;
      end else begin : g_nospill
         assign spill_rd = '0;
      end
   endgenerate
   always_comb begin
      s0_d  = s0_q;
      s1_d  = s1_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q | (i_push & ~i_pop & o_full);
      unf_d = unf_q | (i_pop & o_empty);
      if (do_push) begin
         s0_d  = i_data;
         s1_d  = s0_q;
         cnt_d = cnt_q + CW'(1);
      end
      if (do_pop) begin
         s0_d  = s1_q;
         s1_d  = (cnt_q >= CW'(3)) ? spill_rd : '0;
         cnt_d = cnt_q - CW'(1);
      end
      if (do_rep) s0_d = i_data;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s0_q  <= '0;
         s1_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         s0_q  <= s0_d;
         s1_q  <= s1_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end
   assign o_s0        = s0_q;
   assign o_s1        = s1_q;
   assign o_cnt       = cnt_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = unf_q;
endmodule
